// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: the active-low
// hex segment table, the all-segments-off code and the index-width helper.
package seven_seg_pkg;

  // Segment vector, bit 0 = segment a ... bit 6 = segment g, active-low.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  // Active-low patterns for hex digits 0..F, written g..a (MSB first).
  localparam seg_t SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Width of a digit index for n digits; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_seg_dec.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seven_seg_dec
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Table lookup covers all 16 nibble codes, so no fallback is needed.
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment display scanner.
// A prescaler paces a digit index across NUM_DIGITS digits. New display data
// is staged in a pending register and only promoted to the active register
// when the scan wraps to digit 0, so a frame never shows mixed data.
// Outputs are registered; a one-cycle all-off digit enable separates
// consecutive digits to avoid ghosting.
// Optional build macro: SEVEN_SEG_LZB_EN enables leading-zero blanking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  // With a single digit the index never changes, so no ghost gap is needed.
  localparam logic MULTI = (NUM_DIGITS > 1) ? 1'b1 : 1'b0;

  logic [PW-1:0]           presc_r;
  logic [IW-1:0]           idx_r;
  logic                    tick_s;
  logic                    wrap_s;
  logic                    tick_d_r;

  logic [4*NUM_DIGITS-1:0] pend_val_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic [NUM_DIGITS-1:0]   pend_blank_r;
  logic                    pend_valid_r;

  logic [4*NUM_DIGITS-1:0] act_val_r;
  logic [NUM_DIGITS-1:0]   act_dp_r;
  logic [NUM_DIGITS-1:0]   act_blank_r;

  logic [3:0]              nib_sel_s;
  logic                    dp_sel_s;
  logic                    blank_eff_s;
  logic [NUM_DIGITS-1:0]   an_sel_s;
  logic [NUM_DIGITS-1:0]   lz_blank_s;
  seg_t                    dec_seg_s;

  seg_t                    seg_r;
  logic                    dp_out_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    frame_done_r;

  assign tick_s = (presc_r == PRESC_MAX);
  assign wrap_s = tick_s && (idx_r == IDX_MAX);

  // Prescaler: counts 0..CLK_DIV-1 and restarts after the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Digit index: advances on each tick, wrapping after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r        <= '0;
      tick_d_r     <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      tick_d_r     <= tick_s & MULTI;
      frame_done_r <= wrap_s;
      if (tick_s) begin
        if (idx_r == IDX_MAX) begin
          idx_r <= '0;
        end else begin
          idx_r <= idx_r + IW'(1);
        end
      end
    end
  end

  // Double buffer: loads stage into pending; active only changes at wrap.
  // A load coinciding with the wrap bypasses pending entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_r   <= '0;
      pend_dp_r    <= '0;
      pend_blank_r <= '0;
      pend_valid_r <= 1'b0;
      act_val_r    <= '0;
      act_dp_r     <= '0;
      act_blank_r  <= '0;
    end else if (load && wrap_s) begin
      act_val_r    <= value;
      act_dp_r     <= dp;
      act_blank_r  <= blank;
      pend_valid_r <= 1'b0;
    end else if (load) begin
      pend_val_r   <= value;
      pend_dp_r    <= dp;
      pend_blank_r <= blank;
      pend_valid_r <= 1'b1;
    end else if (wrap_s && pend_valid_r) begin
      act_val_r    <= pend_val_r;
      act_dp_r     <= pend_dp_r;
      act_blank_r  <= pend_blank_r;
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  logic lz_zero_s;

  // Blank zero digits above the most significant non-zero one; digit 0 always shows.
  always_comb begin
    lz_zero_s  = 1'b1;
    lz_blank_s = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_zero_s     = lz_zero_s & (act_val_r[4*k +: 4] == 4'h0);
      lz_blank_s[k] = lz_zero_s;
    end
  end
`else
  // Without leading-zero blanking only the blank request darkens a digit.
  always_comb begin
    lz_blank_s = '0;
  end
`endif

  // Pick the nibble, decimal point and blank state of the digit being scanned.
  always_comb begin
    nib_sel_s   = act_val_r[{idx_r, 2'b00} +: 4];
    dp_sel_s    = act_dp_r[idx_r];
    blank_eff_s = act_blank_r[idx_r] | lz_blank_s[idx_r];
    an_sel_s    = ~(NUM_DIGITS'(1) << idx_r);
  end

  seven_seg_dec u_dec (
    .nibble (nib_sel_s),
    .seg    (dec_seg_s)
  );

  // Output stage: blanked digits keep their enable low so scan timing is unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r    <= SEG_OFF;
      dp_out_r <= 1'b1;
      an_r     <= '1;
    end else begin
      if (tick_d_r) begin
        an_r <= '1;
      end else begin
        an_r <= an_sel_s;
      end
      if (blank_eff_s) begin
        seg_r    <= SEG_OFF;
        dp_out_r <= 1'b1;
      end else begin
        seg_r    <= dec_seg_s;
        dp_out_r <= ~dp_sel_s;
      end
    end
  end

  assign seg        = seg_r;
  assign dp_out     = dp_out_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan with NUM_DIGITS=4, CLK_DIV=4.
// Stimulus pushes the hand-computed segment pattern of every frame it expects;
// a monitor pops one entry each time a new digit enable appears.
module tb_seven_seg_scan;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b1;

  seven_seg_scan #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .load       (load),
    .seg        (seg),
    .dp_out     (dp_out),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame: segments for digits 0..3 and active-low dp_out per digit.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpo);
    exp_t e;
    e.an = 4'b1110; e.seg = s0; e.dp = dpo[0]; exp_q.push_back(e);
    e.an = 4'b1101; e.seg = s1; e.dp = dpo[1]; exp_q.push_back(e);
    e.an = 4'b1011; e.seg = s2; e.dp = dpo[2]; exp_q.push_back(e);
    e.an = 4'b0111; e.seg = s3; e.dp = dpo[3]; exp_q.push_back(e);
  endtask

  task automatic push_zero_frame();
    push_frame(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111);
  endtask

  task automatic push_1234_frame();
    push_frame(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111);
  endtask

  // Wait for the next frame_done pulse, bounded to 40 cycles.
  task automatic wait_fd();
    bit seen = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk("frame_done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Monitor: ghost gap, digit contents and frame period.
  initial begin
    logic [3:0] prev_an = 4'hF;
    int cyc = 0;
    int last_fd = -1;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_an = 4'hF;
        last_fd = -1;
      end else begin
        if (frame_done) begin
          if (last_fd >= 0) chk("frame_period", cyc - last_fd, 32'd16);
          last_fd = cyc;
        end
        if (mon_en && an != 4'hF && an != prev_an) begin
          chk("ghost_gap", {28'd0, prev_an}, 32'hF);
          chk("queue_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("digit_an", {28'd0, an}, {28'd0, e.an});
            chk("digit_seg", {25'd0, seg}, {25'd0, e.seg});
            chk("digit_dp_out", {31'd0, dp_out}, {31'd0, e.dp});
          end
        end
        prev_an = an;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit an_ok = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_seg", {25'd0, seg}, 32'h7F);
    chk("reset_an", {28'd0, an}, 32'hF);
    chk("reset_dp_out", {31'd0, dp_out}, 32'd1);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);

    // Frames 0 and 1 show reset data (all zero).
    push_zero_frame();
    push_zero_frame();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2 && !an_ok; i++) begin
      @(negedge clk);
      if (an == 4'b1110) an_ok = 1'b1;
    end
    chk("an_digit0_after_reset", {31'd0, an_ok}, 32'd1);

    // Load 1234 exactly on the wrap edge ending frame 1.
    wait_fd();
    repeat (15) @(posedge clk);
    #1 pulse_load(16'h1234, 4'h0, 4'h0);
    push_1234_frame();
    push_1234_frame();

    // Mid-frame load of ABCD in frame 3: frame 3 stays 1234, frame 4 ABCD.
    wait_fd();
    repeat (5) @(posedge clk);
    #1 pulse_load(16'hABCD, 4'h0, 4'h0);
    push_frame(7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000, 4'b1111);

    // Two loads in frame 4; the second overwrites pending.
    wait_fd();
    repeat (5) @(posedge clk);
    #1 pulse_load(16'h9876, 4'b0001, 4'b0100);
    repeat (3) @(posedge clk);
    #1 pulse_load(16'hE5F0, 4'b0001, 4'b0100);
    push_frame(7'b1000000, 7'b0001110, 7'b1111111, 7'b0000110, 4'b1110);

    // 0070 in frames 6 and 7; upper zeros depend on leading-zero blanking.
    wait_fd();
    repeat (5) @(posedge clk);
    #1 pulse_load(16'h0070, 4'h0, 4'h0);
`ifdef SEVEN_SEG_LZB_EN
    push_frame(7'b1000000, 7'b1111000, 7'b1111111, 7'b1111111, 4'b1111);
    push_frame(7'b1000000, 7'b1111000, 7'b1111111, 7'b1111111, 4'b1111);
`else
    push_frame(7'b1000000, 7'b1111000, 7'b1000000, 7'b1000000, 4'b1111);
    push_frame(7'b1000000, 7'b1111000, 7'b1000000, 7'b1000000, 4'b1111);
`endif

    // Reset mid-frame 7 with a pending load that must be discarded.
    wait_fd();
    wait_fd();
    repeat (7) @(posedge clk);
    #1 pulse_load(16'h1111, 4'hF, 4'h0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_seg", {25'd0, seg}, 32'h7F);
    chk("midreset_an", {28'd0, an}, 32'hF);
    chk("midreset_dp_out", {31'd0, dp_out}, 32'd1);
    chk("midreset_frame_done", {31'd0, frame_done}, 32'd0);
    exp_q.delete();
    push_zero_frame();
    push_zero_frame();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_fd();
    wait_fd();
    mon_en = 1'b0;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..16).
REQ-002 SHALL have parameter CLK_DIV, default 50000, clock cycles each digit is driven (>=2).
REQ-003 SHALL have port clk, input, 1, single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port value, input, 4*NUM_DIGITS, hex nibbles; nibble k drives digit k (digit 0 = LSB).
REQ-006 SHALL have port dp, input, NUM_DIGITS, per-digit decimal point request, 1 = lit.
REQ-007 SHALL have port blank, input, NUM_DIGITS, per-digit blank request, 1 = dark.
REQ-008 SHALL have port load, input, 1, single-cycle strobe capturing value/dp/blank into the pending register.
REQ-009 SHALL have port seg, output, 7, segments a..g on seg[0]..seg[6], active-low.
REQ-010 SHALL have port dp_out, output, 1, decimal point, active-low.
REQ-011 SHALL have port an, output, NUM_DIGITS, digit enables, active-low, one-cold or all ones.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse when the scan wraps to digit 0.

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and raise an internal tick while at CLK_DIV-1.
REQ-014 On tick the digit index SHALL advance by 1; at index NUM_DIGITS-1 it SHALL wrap to 0.
REQ-015 frame_done SHALL be high exactly in the cycle after the tick that wraps the index.
REQ-016 Load SHALL write value/dp/blank into pending and set a pending-valid flag; a later load before frame wrap SHALL overwrite pending.
REQ-017 At the wrap tick, active SHALL take pending if valid (flag cleared), else stay unchanged; display never tears mid-frame.
REQ-018 A load in the same cycle as the wrap tick SHALL go straight into active; the flag SHALL stay clear.
REQ-019 seg/dp_out/an SHALL be registered, reflecting the current index and active data one cycle later.
REQ-020 Hex encoding (active-low, g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-021 Blanked digit SHALL drive seg=7'h7F, dp_out=1, and its an bit low (position timing preserved).
REQ-022 In the cycle an index change reaches the outputs, an SHALL be all ones for one cycle (ghost guard), then the new digit.

Reset
REQ-023 rst_n low SHALL immediately force seg=7'h7F, dp_out=1, an=all ones, frame_done=0.
REQ-024 Reset SHALL clear prescaler, index, active, pending and pending-valid to 0; scan restarts at digit 0.
REQ-025 Reset asserted mid-frame SHALL discard any pending load.

Configuration
REQ-026 With macro SEVEN_SEG_LZB_EN defined, leading-zero blanking SHALL apply: zero digits above the most significant non-zero active digit are blanked; digit 0 is never blanked by this rule.
REQ-027 Without SEVEN_SEG_LZB_EN, only the blank input SHALL blank digits; zero nibbles display "0".

Structure
REQ-028 Package seven_seg_pkg SHALL hold the 16-entry segment table, SEG_OFF (7'h7F) and index-width function.
REQ-029 Combinational sub-module seven_seg_dec (4-bit nibble to 7-bit active-low segments) SHALL be instantiated once on the selected nibble.

Verification (NUM_DIGITS=4, CLK_DIV=4)
REQ-030 Reset release -> seg=7'h7F, an=4'hF in the reset cycle; an=4'b1110 within 2 cycles.
REQ-031 load value=16'h1234 at first frame wrap -> digit 0 shows seg=7'b0011001, digit 3 shows 7'b1111001, frame_done every 16 cycles.
REQ-032 load 16'hABCD mid-frame -> current frame shows 1234 to completion; ABCD from next digit 0.
REQ-033 blank=4'b0100, dp=4'b0001 -> digit 2 seg=7'h7F with an[2]=0; digit 0 dp_out=0.
REQ-034 SEVEN_SEG_LZB_EN, value=16'h0070 -> digits 3,2 blanked, digit 1 7'b1111000, digit 0 7'b1000000; without macro digits 3,2 show 7'b1000000.
REQ-035 rst_n pulsed low mid-frame with pending load -> outputs off immediately; after release scan from digit 0 with value 0.
